// File: rtl/uart_mem_responder_pkg.sv
// Shared types and constants for the memory-side UART request responder.
package uart_mem_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Frame header encodings
  localparam logic [7:0] HDR_IREAD    = 8'h01;
  localparam logic [7:0] HDR_DREAD    = 8'h05;
  localparam logic [3:0] HDR_WRITE_LO = 4'h9;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_MEM   = 3'd3,
    ST_REPLY = 3'd4
  } state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_t;

  // Instruction and data reads share one path; only the header differs.
  function automatic logic hdr_is_read(input logic [7:0] hdr);
    return (hdr == HDR_IREAD) || (hdr == HDR_DREAD);
  endfunction

  // Writes carry the byte mask in the high nibble, so only the low nibble identifies them.
  function automatic logic hdr_is_write(input logic [3:0] hdr_lo);
    return hdr_lo == HDR_WRITE_LO;
  endfunction

endpackage

// File: rtl/uart_mem_responder_if.sv
// Bundle of the UART byte link and the word-wide memory port seen by the responder.
//
// Handshakes: recv_flag / send_flag are single-cycle strobes that the responder raises
// only when the partner already signals receivable / sendable, and never two cycles in a
// row, so the UART FIFO pops or pushes exactly one byte per strobe. mem_req is raised
// with addr/we/wmask/wdata stable and held until the cycle mem_ack is seen high; mem_rdata
// is only meaningful in that ack cycle and mem_ack is ignored while mem_req is low.
interface uart_mem_responder_if;
  import uart_mem_responder_pkg::*;

  logic              receivable;
  logic [7:0]        recv_data;
  logic              recv_flag;
  logic              sendable;
  logic              send_flag;
  logic [7:0]        send_data;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_wmask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              frame_err;

  // Responder side
  modport master (
    input  receivable, recv_data, sendable, mem_ack, mem_rdata,
    output recv_flag, send_flag, send_data,
    output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, frame_err
  );

  // UART wrapper / RAM side
  modport slave (
    output receivable, recv_data, sendable, mem_ack, mem_rdata,
    input  recv_flag, send_flag, send_data,
    input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, frame_err
  );

endinterface

// File: rtl/uart_mem_responder.sv
// Memory-side end of the CPU<->memory UART link: parses request frames byte by byte,
// runs one memory access at a time and streams read data back LSB first.
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_mem_responder_if.master bus,
  output state_t               state_dbg
);

  localparam int IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IdleW-1:0] IdleLimit = IdleW'(TIMEOUT);

  state_t            state_q, state_d;
  kind_t             kind_q;
  logic [1:0]        bcnt_q;
  logic [IdleW-1:0]  idle_q;
  logic [3:0]        mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              recv_flag_q;
  logic              send_flag_q;
  logic [7:0]        send_data_q;
  logic              frame_err_q;

  logic in_rx, take, push, ack, tmo, bad_hdr, last_byte;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_HDR;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR:   if (take && !bad_hdr) state_d = ST_ADDR;
      ST_ADDR: begin
        if (tmo)                    state_d = ST_HDR;
        else if (take && last_byte) state_d = (kind_q == KIND_WRITE) ? ST_DATA : ST_MEM;
      end
      ST_DATA: begin
        if (tmo)                    state_d = ST_HDR;
        else if (take && last_byte) state_d = ST_MEM;
      end
      // Writes complete silently; the CPU side does not wait for an acknowledgement byte.
      ST_MEM:   if (ack) state_d = (kind_q == KIND_WRITE) ? ST_HDR : ST_REPLY;
      ST_REPLY: if (push && last_byte) state_d = ST_HDR;
      default:  state_d = ST_HDR;
    endcase
  end

  // Per-cycle control strobes decoded from state and link status
  always_comb begin
    in_rx     = (state_q == ST_HDR) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    // The strobe of the previous pop blocks a second pop while the FIFO advances.
    take      = in_rx && bus.receivable && !recv_flag_q;
    push      = (state_q == ST_REPLY) && bus.sendable && !send_flag_q;
    ack       = (state_q == ST_MEM) && bus.mem_ack;
    // A byte arriving in the expiry cycle still counts, so the timeout only fires when idle.
    tmo       = (TIMEOUT != 0) && ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                !take && (idle_q == IdleLimit);
    bad_hdr   = (state_q == ST_HDR) && take &&
                !hdr_is_read(bus.recv_data) && !hdr_is_write(bus.recv_data[3:0]);
    last_byte = (bcnt_q == 2'd3);
  end

  // Datapath: byte assembly, strobes, idle counter and reply serialisation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q      <= KIND_READ;
      bcnt_q      <= 2'd0;
      idle_q      <= '0;
      mask_q      <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      recv_flag_q <= 1'b0;
      send_flag_q <= 1'b0;
      send_data_q <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      recv_flag_q <= take;
      send_flag_q <= push;
      frame_err_q <= bad_hdr || tmo;

      if (take || !((state_q == ST_ADDR) || (state_q == ST_DATA))) idle_q <= '0;
      else if (idle_q != {IdleW{1'b1}})                              idle_q <= idle_q + 1'b1;

      case (state_q)
        ST_HDR: begin
          bcnt_q <= 2'd0;
          if (take && hdr_is_read(bus.recv_data)) begin
            kind_q <= KIND_READ;
            mask_q <= 4'h0;
          end else if (take && hdr_is_write(bus.recv_data[3:0])) begin
            kind_q <= KIND_WRITE;
            mask_q <= bus.recv_data[7:4];
          end
        end
        ST_ADDR: begin
          if (tmo) bcnt_q <= 2'd0;
          else if (take) begin
            addr_q[{bcnt_q, 3'b000} +: 8] <= bus.recv_data;
            bcnt_q <= bcnt_q + 2'd1;
          end
        end
        ST_DATA: begin
          if (tmo) bcnt_q <= 2'd0;
          else if (take) begin
            wdata_q[{bcnt_q, 3'b000} +: 8] <= bus.recv_data;
            bcnt_q <= bcnt_q + 2'd1;
          end
        end
        ST_MEM: begin
          bcnt_q <= 2'd0;
          if (ack && (kind_q == KIND_READ)) rdata_q <= bus.mem_rdata;
        end
        ST_REPLY: begin
          if (push) begin
            send_data_q <= rdata_q[{bcnt_q, 3'b000} +: 8];
            bcnt_q      <= bcnt_q + 2'd1;
          end
        end
        default: bcnt_q <= 2'd0;
      endcase
    end
  end

  // mem_req follows the state directly so an asynchronous reset drops it at once.
  assign bus.mem_req   = (state_q == ST_MEM);
  assign bus.mem_we    = bus.mem_req && (kind_q == KIND_WRITE);
  assign bus.mem_wmask = bus.mem_we ? mask_q : 4'h0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.recv_flag = recv_flag_q;
  assign bus.send_flag = send_flag_q;
  assign bus.send_data = send_data_q;
  assign bus.frame_err = frame_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed bench for uart_mem_responder: UART FIFO and RAM models plus linear test steps.
module tb_uart_mem_responder;
  import uart_mem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_mem_responder_if bus();
  state_t state_dbg;

  uart_mem_responder #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- UART RX model (byte FIFO, popped by recv_flag) ----------------
  logic [7:0] rx_q[$];
  int rx_rd = 0;
  always @(negedge clk) begin
    if (bus.recv_flag && rx_rd < rx_q.size()) rx_rd++;
    bus.receivable = (rx_rd < rx_q.size());
    bus.recv_data  = (rx_rd < rx_q.size()) ? rx_q[rx_rd] : 8'h00;
  end

  // ---------------- RAM model ----------------
  int          mem_delay = 0;
  logic [31:0] mem_rdata_val = 32'h0;
  int          mem_wait = 0;
  always @(negedge clk) begin
    if (bus.mem_req && !bus.mem_ack) begin
      if (mem_wait >= mem_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_rdata_val;
        mem_wait      = 0;
      end else begin
        mem_wait++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
    end
  end

  // ---------------- monitors ----------------
  logic [7:0]  tx_got[$];
  int          tx_cyc[$];
  int          last_recv_cyc = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;
  int          req_cnt = 0;
  int          req_hi = 0;
  int          req_unstable = 0;
  logic        prev_req = 1'b0;
  logic [31:0] cap_addr = 0, cap_wdata = 0;
  logic        cap_we = 0;
  logic [3:0]  cap_mask = 0;

  always @(negedge clk) begin
    if (bus.recv_flag) last_recv_cyc = cyc;
    if (bus.send_flag) begin
      tx_got.push_back(bus.send_data);
      tx_cyc.push_back(cyc);
    end
    if (bus.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.mem_req) begin
      if (!prev_req) begin
        req_cnt++;
        req_hi    = 1;
        cap_addr  = bus.mem_addr;
        cap_we    = bus.mem_we;
        cap_mask  = bus.mem_wmask;
        cap_wdata = bus.mem_wdata;
      end else begin
        req_hi++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wmask, bus.mem_wdata} !==
            {cap_addr, cap_we, cap_mask, cap_wdata}) req_unstable++;
      end
    end
    prev_req = bus.mem_req;
  end

  // ---------------- scoreboard / driver tasks ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic send_bytes(input logic [7:0] b[]);
    foreach (b[i]) rx_q.push_back(b[i]);
  endtask

  task automatic wait_state(input string tag, input state_t s, input int budget);
    int i = 0;
    while (state_dbg != s && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(state_dbg), 32'(s));
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int i = 0;
    while (tx_got.size() < n && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(tx_got.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int n, input int budget);
    int i = 0;
    while (req_cnt < n && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(req_cnt), 32'(n));
  endtask

  // Compares the bytes sent since index base against exp_q, draining it.
  task automatic check_tx(input string tag, input int base);
    int i = 0;
    check({tag, "_count"}, 32'(tx_got.size() - base), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_byte%0d", tag, i),
            (base + i < tx_got.size()) ? {24'h0, tx_got[base + i]} : 32'hFFFF_FFFF,
            {24'h0, e});
      i++;
    end
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int base, reqs, errs, d;
    bus.sendable = 1'b1;
    rst = 1'b0;
    step(3);

    // Reset state
    check("rst_ctrl", {16'h0, bus.recv_flag, bus.send_flag, bus.send_data, bus.mem_req,
                       bus.mem_we, bus.mem_wmask, bus.frame_err}, 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_HDR));
    rst = 1'b1;
    step(2);

    // Instruction read of 0x1234
    base = tx_got.size();
    mem_rdata_val = 32'hDEAD_BEEF;
    send_bytes('{8'h01, 8'h34, 8'h12, 8'h00, 8'h00});
    wait_tx("iread_wait", base + 4, 200);
    check("iread_addr", cap_addr, 32'h0000_1234);
    check("iread_we", {31'h0, cap_we}, 32'h0);
    d = tx_cyc[base] - last_recv_cyc;
    check("iread_latency", 32'((d > 0) && (d <= 4)), 32'd1);
    step(5);
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_tx("iread_tx", base);
    check("iread_state", 32'(state_dbg), 32'(ST_HDR));

    // Masked write, no reply expected
    base = tx_got.size();
    reqs = req_cnt;
    send_bytes('{8'h59, 8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
    wait_req("wr_wait", reqs + 1, 200);
    step(10);
    check("wr_addr", cap_addr, 32'h0000_0008);
    check("wr_we", {31'h0, cap_we}, 32'h1);
    check("wr_mask", {28'h0, cap_mask}, 32'h5);
    check("wr_wdata", cap_wdata, 32'h1122_3344);
    check("wr_no_tx", 32'(tx_got.size() - base), 32'd0);
    check("wr_state", 32'(state_dbg), 32'(ST_HDR));

    // Bad header then a data read of address 4
    base = tx_got.size();
    errs = err_cnt;
    mem_rdata_val = 32'hCAFE_F00D;
    send_bytes('{8'h07, 8'h05, 8'h04, 8'h00, 8'h00, 8'h00});
    wait_tx("badhdr_wait", base + 4, 200);
    step(5);
    check("badhdr_err", 32'(err_cnt - errs), 32'd1);
    check("badhdr_addr", cap_addr, 32'h0000_0004);
    exp_q = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    check_tx("badhdr_tx", base);

    // Inter-byte timeout after two bytes of a frame
    errs = err_cnt;
    reqs = req_cnt;
    send_bytes('{8'h05, 8'h04});
    step(6);
    check("tmo_state_mid", 32'(state_dbg), 32'(ST_ADDR));
    step(20);
    check("tmo_err", 32'(err_cnt - errs), 32'd1);
    d = err_cyc - last_recv_cyc;
    check("tmo_window", 32'((d >= 16) && (d <= 18)), 32'd1);
    check("tmo_no_req", 32'(req_cnt - reqs), 32'd0);
    check("tmo_state", 32'(state_dbg), 32'(ST_HDR));

    // Full frame after the timeout
    base = tx_got.size();
    mem_rdata_val = 32'h0102_0304;
    send_bytes('{8'h05, 8'h20, 8'h00, 8'h00, 8'h00});
    wait_tx("post_tmo_wait", base + 4, 200);
    step(5);
    check("post_tmo_addr", cap_addr, 32'h0000_0020);
    exp_q = '{8'h04, 8'h03, 8'h02, 8'h01};
    check_tx("post_tmo_tx", base);

    // Back-pressure: slow memory and TX stalled during the reply
    base = tx_got.size();
    bus.sendable = 1'b0;
    mem_delay = 7;
    mem_rdata_val = 32'h55AA_33CC;
    send_bytes('{8'h05, 8'h40, 8'h00, 8'h00, 8'h00});
    wait_state("bp_reply_wait", ST_REPLY, 200);
    check("bp_req_hold", 32'(req_hi), 32'd8);
    check("bp_req_stable", 32'(req_unstable), 32'd0);
    check("bp_addr", cap_addr, 32'h0000_0040);
    step(50);
    check("bp_stalled", 32'(tx_got.size() - base), 32'd0);
    bus.sendable = 1'b1;
    wait_tx("bp_tx_wait", base + 4, 200);
    step(10);
    exp_q = '{8'hCC, 8'h33, 8'hAA, 8'h55};
    check_tx("bp_tx", base);
    mem_delay = 0;

    // Asynchronous reset in the middle of a reply
    bus.sendable = 1'b0;
    mem_rdata_val = 32'h9988_7766;
    send_bytes('{8'h05, 8'h80, 8'h00, 8'h00, 8'h00});
    wait_state("mid_reply_wait", ST_REPLY, 200);
    step(3);
    rst = 1'b0;
    #1;
    check("midrst_ctrl", {16'h0, bus.recv_flag, bus.send_flag, bus.send_data, bus.mem_req,
                          bus.mem_we, bus.mem_wmask, bus.frame_err}, 32'h0);
    check("midrst_addr", bus.mem_addr, 32'h0);
    check("midrst_state", 32'(state_dbg), 32'(ST_HDR));
    step(2);
    bus.sendable = 1'b1;
    rst = 1'b1;
    step(2);
    base = tx_got.size();
    mem_rdata_val = 32'h0BAD_C0DE;
    send_bytes('{8'h01, 8'h00, 8'h10, 8'h00, 8'h00});
    wait_tx("after_rst_wait", base + 4, 200);
    step(5);
    check("after_rst_addr", cap_addr, 32'h0000_1000);
    exp_q = '{8'hDE, 8'hC0, 8'hAD, 8'h0B};
    check_tx("after_rst_tx", base);
    check("after_rst_state", 32'(state_dbg), 32'(ST_HDR));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
